// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, branch opcodes and fetch FSM states.
// Optional build macro used across the slice: FETCH_INSTR_COUNT_EN.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;

  localparam logic [5:0] OP_B   = 6'b000101;
  localparam logic [7:0] OP_CBZ = 8'b10110100;
  localparam logic [7:0] OP_BLT = 8'b01010100;

  typedef enum logic {
    RUN,
    HALT
  } fetch_state_t;

  // A "B ." with a zero offset is used as the halt marker.
  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return (instr[31:26] == OP_B) && (instr[25:0] == 26'd0);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: decode-side control, instruction-memory port and IF/ID outputs.
// FETCH_INSTR_COUNT_EN adds the instr_count signal.
interface fetch_stage_if;
  import cpu_pkg::*;

  logic               stall;
  logic               flush;
  logic               br_taken;
  logic               uncond_br;
  logic [INSTR_W-1:0] imem_instr;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] id_instr;
  logic [ADDR_W-1:0]  id_pc;
  logic               id_valid;
  logic               halted;
`ifdef FETCH_INSTR_COUNT_EN
  logic [31:0]        instr_count;
`endif

  modport master (
    output stall, flush, br_taken, uncond_br, imem_instr,
    input  imem_addr, id_instr, id_pc, id_valid, halted
`ifdef FETCH_INSTR_COUNT_EN
    , input instr_count
`endif
  );

  modport slave (
    input  stall, flush, br_taken, uncond_br, imem_instr,
    output imem_addr, id_instr, id_pc, id_valid, halted
`ifdef FETCH_INSTR_COUNT_EN
    , output instr_count
`endif
  );

endinterface

// File: rtl/fetch_stage_branch_target.sv
// Combinational branch target: id_pc plus the sign-extended word offset of B or CBZ/B.LT.
module branch_target
  import cpu_pkg::*;
(
   input  logic [ADDR_W-1:0]  pc,
   input  logic [INSTR_W-1:0] instr,
   input  logic               uncond_br,
   output logic [ADDR_W-1:0]  target
);

   logic [ADDR_W-1:0] offset;
   logic              unused_bits;

   assign unused_bits = ^{instr[31:26], instr[4:0]};

   always_comb begin
      if (uncond_br)
         offset = {{36{instr[25]}}, instr[25:0], 2'b00};
      else
         offset = {{43{instr[23]}}, instr[23:5], 2'b00};
   end

   // Wraps modulo 2^64 by construction.
   assign target = pc + offset;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, IF/ID register and a RUN/HALT control FSM.
// Define FETCH_INSTR_COUNT_EN to add the saturating instr_count output.
module fetch_stage
  import cpu_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   fetch_stage_if.slave  bus
);

   fetch_state_t       state;
   logic [ADDR_W-1:0]  pc;
   logic [ADDR_W-1:0]  id_pc;
   logic [INSTR_W-1:0] id_instr;
   logic               id_valid;
   logic               halted;
   logic [ADDR_W-1:0]  target;
   logic               halt_seen;
   logic               redirect;
   logic               fetch_valid;

   branch_target u_branch_target (
      .pc        (id_pc),
      .instr     (id_instr),
      .uncond_br (bus.uncond_br),
      .target    (target)
   );

   assign halt_seen   = id_valid && is_halt(id_instr);
   assign redirect    = id_valid && bus.br_taken && !halt_seen;
   assign fetch_valid = (state == RUN) && !halt_seen && !redirect && !bus.stall && !bus.flush;

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= RUN;
         pc       <= '0;
         id_pc    <= '0;
         id_instr <= '0;
         id_valid <= 1'b0;
         halted   <= 1'b0;
      end else if (state == HALT) begin
         id_valid <= 1'b0;
         halted   <= 1'b1;
      end else if (halt_seen) begin
         state    <= HALT;
         id_valid <= 1'b0;
         halted   <= 1'b1;
      end else if (redirect) begin
         pc       <= target;
         id_valid <= 1'b0;
      end else if (bus.stall) begin
         if (bus.flush)
            id_valid <= 1'b0;
      end else begin
         pc       <= pc + ADDR_W'(4);
         id_instr <= bus.imem_instr;
         id_pc    <= pc;
         id_valid <= !bus.flush;
      end
   end

   assign bus.imem_addr = pc;
   assign bus.id_instr  = id_instr;
   assign bus.id_pc     = id_pc;
   assign bus.id_valid  = id_valid;
   assign bus.halted    = halted;

`ifdef FETCH_INSTR_COUNT_EN
   logic [31:0] instr_count;

   always_ff @(posedge clk) begin
      if (reset)
         instr_count <= '0;
      else if (fetch_valid && (instr_count != 32'hFFFF_FFFF))
         instr_count <= instr_count + 32'd1;
   end

   assign bus.instr_count = instr_count;
`else
   logic unused_fetch_valid;
   assign unused_fetch_valid = fetch_valid;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequencing, branches, stall, flush, wrap, halt and reset.
// Define FETCH_INSTR_COUNT_EN to also exercise instr_count.
module tb_fetch_stage;
  import cpu_pkg::*;

  localparam logic [31:0] NOP = 32'hD503_201F;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] imem [256];

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_instr = imem[bus.imem_addr[9:2]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_if(input string tag, input logic [63:0] addr, input logic [63:0] pc,
                          input logic valid);
    check({tag, " imem_addr"}, bus.imem_addr, addr);
    check({tag, " id_pc"}, bus.id_pc, pc);
    check({tag, " id_valid"}, 64'(bus.id_valid), 64'(valid));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = NOP;
    imem[4]  = 32'h1400_0003;  // 0x10: B +3 words
    imem[7]  = 32'h1400_0008;  // 0x1C: B +8 words
    imem[16] = 32'hB4FF_FFC0;  // 0x40: CBZ -2 words
    imem[18] = 32'h17FF_FFED;  // 0x48: B -0x13 words

    reset = 1'b1;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.br_taken = 1'b0; bus.uncond_br = 1'b0;
    step();
    check_if("reset", 64'h0, 64'h0, 1'b0);
    check("reset id_instr", 64'(bus.id_instr), 64'h0);
    check("reset halted", 64'(bus.halted), 64'h0);
    reset = 1'b0;

    // Free-running fetch
    step(); check_if("run1", 64'h4, 64'h0, 1'b1);
    check("run1 id_instr", 64'(bus.id_instr), 64'(NOP));
    step(); check_if("run2", 64'h8, 64'h4, 1'b1);
    step(); check_if("run3", 64'hC, 64'h8, 1'b1);
    step(); check_if("run4", 64'h10, 64'hC, 1'b1);
    step(); check_if("b_in_id", 64'h14, 64'h10, 1'b1);
    check("b_in_id id_instr", 64'(bus.id_instr), 64'h1400_0003);

    // Unconditional branch taken: one bubble
    bus.br_taken = 1'b1; bus.uncond_br = 1'b1;
    step(); check_if("b_redirect", 64'h1C, 64'h10, 1'b0);
    bus.br_taken = 1'b0;
    step(); check_if("b_after", 64'h20, 64'h1C, 1'b1);

    // Stall two cycles, redirect arrives during the second
    bus.stall = 1'b1;
    step(); check_if("stall1", 64'h20, 64'h1C, 1'b1);
    check("stall1 id_instr", 64'(bus.id_instr), 64'h1400_0008);
    bus.br_taken = 1'b1;
    step(); check_if("stall2_redirect", 64'h3C, 64'h1C, 1'b0);
    bus.stall = 1'b0; bus.br_taken = 1'b0;
    step(); check_if("post_stall", 64'h40, 64'h3C, 1'b1);
    step(); check_if("cbz_in_id", 64'h44, 64'h40, 1'b1);

    // Conditional branch, negative offset; br_taken then held over the bubble
    bus.br_taken = 1'b1; bus.uncond_br = 1'b0;
    step(); check_if("cbz_redirect", 64'h38, 64'h40, 1'b0);
    step(); check_if("bubble_ignores_br", 64'h3C, 64'h38, 1'b1);
    bus.br_taken = 1'b0;
    step(); check_if("seq_3c", 64'h40, 64'h3C, 1'b1);
    step(); check_if("cbz_not_taken", 64'h44, 64'h40, 1'b1);

    // Flush invalidates ID while the PC keeps advancing
    bus.flush = 1'b1;
    step(); check_if("flush", 64'h48, 64'h44, 1'b0);
    bus.flush = 1'b0;
    step(); check_if("after_flush", 64'h4C, 64'h48, 1'b1);

    // Branch to the top of the address space, then wrap through zero
    bus.br_taken = 1'b1; bus.uncond_br = 1'b1;
    step(); check_if("to_top", 64'hFFFF_FFFF_FFFF_FFFC, 64'h48, 1'b0);
    bus.br_taken = 1'b0;
    step(); check_if("wrap", 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    step(); check_if("wrap_next", 64'h4, 64'h0, 1'b1);

    // Reset wins over simultaneous stall, flush and branch
    reset = 1'b1; bus.stall = 1'b1; bus.flush = 1'b1; bus.br_taken = 1'b1;
    step(); check_if("reset_prio", 64'h0, 64'h0, 1'b0);
    reset = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0; bus.br_taken = 1'b0;
    imem[2] = 32'h1400_0000;
    step(); check_if("h_run1", 64'h4, 64'h0, 1'b1);
    step(); check_if("h_run2", 64'h8, 64'h4, 1'b1);
    step(); check_if("halt_in_id", 64'hC, 64'h8, 1'b1);
    check("halt_in_id halted", 64'(bus.halted), 64'h0);

    // Halt beats stall and branch, then holds for 10 cycles whatever the inputs
    bus.stall = 1'b1; bus.br_taken = 1'b1;
    step();
    check("halt imem_addr", bus.imem_addr, 64'hC);
    check("halt id_valid", 64'(bus.id_valid), 64'h0);
    check("halt halted", 64'(bus.halted), 64'h1);
    for (int i = 0; i < 10; i++) begin
      bus.stall = i[0]; bus.flush = i[1]; bus.br_taken = i[2]; bus.uncond_br = i[0];
      step();
      check("halted imem_addr", bus.imem_addr, 64'hC);
      check("halted id_valid", 64'(bus.id_valid), 64'h0);
      check("halted halted", 64'(bus.halted), 64'h1);
    end
    reset = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0; bus.br_taken = 1'b0;
    step();
    check("halt_reset imem_addr", bus.imem_addr, 64'h0);
    check("halt_reset halted", 64'(bus.halted), 64'h0);
    check("halt_reset id_valid", 64'(bus.id_valid), 64'h0);
    imem[2] = NOP;

`ifdef FETCH_INSTR_COUNT_EN
    check("count reset", 64'(bus.instr_count), 64'h0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("count 5 fetches", 64'(bus.instr_count), 64'd5);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0; bus.stall = 1'b1;
    step();
    bus.stall = 1'b0;
    check("count flush+stall", 64'(bus.instr_count), 64'd5);
    check("count pc", bus.imem_addr, 64'h18);
`else
    reset = 1'b0;
    step();
    check_if("post_reset", 64'h4, 64'h0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
